// File: rtl/fib_request_arbiter.sv
// -----------------------------------------------------------------------------
// fib_request_arbiter
//
// Purpose:
//   Shares one fibonacci_generator among NUM_REQ requesters using round-robin
//   arbitration. The winner's iteration count is latched and sent to the
//   generator with a single start pulse. The generator result and overflow flag
//   are captured when it finishes. They are returned with a one-cycle done pulse
//   to the requester that owned the generator.
//
// Optional feature:
//   FIB_ARB_WATCHDOG_EN - when defined, WAIT aborts after TIMEOUT_CYCLES without
//   gen_done_i. The aborted job reports result 0 and overflow 1, and timeout_o
//   pulses together with done_o. When undefined, WAIT waits indefinitely and
//   timeout_o is tied low.
//
// Ports:
//   clk_i, reset_i    clock and synchronous active-high reset
//   req_i             level request, one bit per requester
//   iterations_i      requester k count at [k*ITER_W +: ITER_W]
//   grant_o           one-hot owner of the generator, 0 when idle
//   done_o            one-cycle pulse to the owner when result_o is valid
//   result_o          registered result, holds until the next completion
//   overflow_o        registered overflow flag, updates with result_o
//   busy_o            high in every state except IDLE
//   gen_start_o       one-cycle start pulse to the generator
//   gen_iterations_o  latched iteration count for the generator
//   gen_done_i        generator completion strobe
//   gen_fibonacci_i   generator result
//   gen_overflow_i    generator overflow flag
//   timeout_o         watchdog abort indication, pulses with done_o
//
// Handshake:
//   A requester holds req_i until it sees its done_o bit. The transaction is
//   committed at grant time, so dropping req_i early does not cancel it.
//   grant_o stays high from LAUNCH through RESPOND. done_o is grant_o gated by
//   the RESPOND state, so it never goes to a requester that was not granted.
// -----------------------------------------------------------------------------
module fib_request_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ITER_W         = 7,
    parameter int RESULT_W       = 14,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*ITER_W-1:0]  iterations_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic [RESULT_W-1:0]        result_o,
    output logic                       overflow_o,
    output logic                       busy_o,
    output logic                       gen_start_o,
    output logic [ITER_W-1:0]          gen_iterations_o,
    input  logic                       gen_done_i,
    input  logic [RESULT_W-1:0]        gen_fibonacci_i,
    input  logic                       gen_overflow_i,
    output logic                       timeout_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                overflow_q, overflow_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;

`ifdef FIB_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timed_out_q, timed_out_d;
`endif

    // Search from the requester after the last one served. The search wraps
    // around, so the last winner is checked last.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!pick_valid && req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        iter_d     = iter_q;
        grant_d    = grant_q;
        result_d   = result_q;
        overflow_d = overflow_q;
`ifdef FIB_ARB_WATCHDOG_EN
        wd_cnt_d    = wd_cnt_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    iter_d  = iterations_i[int'(pick_idx)*ITER_W +: ITER_W];
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
`ifdef FIB_ARB_WATCHDOG_EN
                wd_cnt_d    = '0;
                timed_out_d = 1'b0;
`endif
            end
            ST_WAIT: begin
                // A real completion wins over a watchdog expiry in the same cycle.
                if (gen_done_i) begin
                    result_d   = gen_fibonacci_i;
                    overflow_d = gen_overflow_i;
                    state_d    = ST_RESPOND;
                end
`ifdef FIB_ARB_WATCHDOG_EN
                else if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d    = '0;
                    overflow_d  = 1'b1;
                    timed_out_d = 1'b1;
                    state_d     = ST_RESPOND;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            ST_RESPOND: begin
                ptr_d   = idx_q;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            idx_q      <= '0;
            iter_q     <= '0;
            grant_q    <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            iter_q     <= iter_d;
            grant_q    <= grant_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef FIB_ARB_WATCHDOG_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign timeout_o = (state_q == ST_RESPOND) && timed_out_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign grant_o          = grant_q;
    assign done_o           = (state_q == ST_RESPOND) ? grant_q : '0;
    assign result_o         = result_q;
    assign overflow_o       = overflow_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign gen_start_o      = (state_q == ST_LAUNCH);
    assign gen_iterations_o = iter_q;

endmodule

// File: tb/tb_fib_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fib_request_arbiter
//
// Self-checking bench for fib_request_arbiter. A behavioural generator model
// answers each start pulse. Expected transactions are queued when requests are
// driven. They are checked at gen_start_o (owner and iteration count) and
// popped at done_o (owner, result, overflow and timeout).
// -----------------------------------------------------------------------------
module tb_fib_request_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ITER_W   = 7;
  localparam int RESULT_W = 14;
  localparam int TIMEOUT  = 16;
  localparam int EXP_W    = NUM_REQ + ITER_W + RESULT_W + 2;

  logic                      clk;
  logic                      reset_i;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*ITER_W-1:0] iterations_i;
  logic [NUM_REQ-1:0]        grant_o;
  logic [NUM_REQ-1:0]        done_o;
  logic [RESULT_W-1:0]       result_o;
  logic                      overflow_o;
  logic                      busy_o;
  logic                      gen_start_o;
  logic [ITER_W-1:0]         gen_iterations_o;
  logic                      gen_done_i;
  logic [RESULT_W-1:0]       gen_fibonacci_i;
  logic                      gen_overflow_i;
  logic                      timeout_o;

  fib_request_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ITER_W         (ITER_W),
    .RESULT_W       (RESULT_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .req_i            (req_i),
    .iterations_i     (iterations_i),
    .grant_o          (grant_o),
    .done_o           (done_o),
    .result_o         (result_o),
    .overflow_o       (overflow_o),
    .busy_o           (busy_o),
    .gen_start_o      (gen_start_o),
    .gen_iterations_o (gen_iterations_o),
    .gen_done_i       (gen_done_i),
    .gen_fibonacci_i  (gen_fibonacci_i),
    .gen_overflow_i   (gen_overflow_i),
    .timeout_o        (timeout_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cnt = 0;
  int start_cyc = 0;

  // generator model controls
  int   gen_delay    = 0;
  logic gen_silent   = 1'b0;
  logic gen_force_ov = 1'b0;
  int   inject_req   = 0;
  int   inject_seen  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void fib_model(input int n, output logic [RESULT_W-1:0] r, output logic ov);
    longint a, b, t;
    a = 0;
    b = 1;
    ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
      if (a > 64'd16383) ov = 1'b1;
    end
    r = a[RESULT_W-1:0];
  endfunction

  task automatic push_exp(input int idx, input int iter, input int res, input logic ov, input logic to);
    logic [NUM_REQ-1:0]  g;
    logic [ITER_W-1:0]   it;
    logic [RESULT_W-1:0] rs;
    g  = '0;
    g[idx] = 1'b1;
    it = ITER_W'(iter);
    rs = RESULT_W'(res);
    exp_q.push_back({g, it, rs, ov, to});
  endtask

  // ---------------- generator model ----------------
  initial begin : gen_model
    logic [RESULT_W-1:0] r;
    logic ov;
    int d;
    gen_done_i      = 1'b0;
    gen_fibonacci_i = '0;
    gen_overflow_i  = 1'b0;
    forever begin
      @(negedge clk);
      if (inject_req != inject_seen) begin
        inject_seen     = inject_req;
        gen_fibonacci_i = 14'h0123;
        gen_overflow_i  = 1'b0;
        gen_done_i      = 1'b1;
        @(negedge clk);
        gen_done_i = 1'b0;
      end else if (gen_start_o && !reset_i && !gen_silent) begin
        fib_model(int'(gen_iterations_o), r, ov);
        if (gen_force_ov) begin
          r  = '1;
          ov = 1'b1;
        end
        d = (gen_delay != 0) ? gen_delay : int'($urandom_range(1, 8));
        repeat (d) @(negedge clk);
        gen_fibonacci_i = r;
        gen_overflow_i  = ov;
        gen_done_i      = 1'b1;
        @(negedge clk);
        gen_done_i = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [EXP_W-1:0]    e;
    logic [NUM_REQ-1:0]  e_g;
    logic [ITER_W-1:0]   e_it;
    logic [RESULT_W-1:0] e_rs;
    logic                e_ov, e_to;
    cyc++;
    if (!reset_i) begin
      if (busy_o) check_eq("grant_onehot", 32'($onehot(grant_o)), 32'd1);
      if (gen_start_o) begin
        start_cnt++;
        start_cyc = cyc;
        if (exp_q.size() == 0) check_eq("start_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q[0];
          {e_g, e_it, e_rs, e_ov, e_to} = e;
          check_eq("grant_at_start", 32'(grant_o), 32'(e_g));
          check_eq("iter_at_start", 32'(gen_iterations_o), 32'(e_it));
        end
      end
      if (|done_o) begin
        if (exp_q.size() == 0) check_eq("done_unexpected", 32'(done_o), 32'd0);
        else begin
          e = exp_q.pop_front();
          {e_g, e_it, e_rs, e_ov, e_to} = e;
          check_eq("done_owner", 32'(done_o), 32'(e_g));
          check_eq("result", 32'(result_o), 32'(e_rs));
          check_eq("overflow", 32'(overflow_o), 32'(e_ov));
          check_eq("timeout", 32'(timeout_o), 32'(e_to));
          if (e_to) check_eq("timeout_latency", 32'(cyc - start_cyc), 32'(TIMEOUT + 1));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_iter(input int k, input int v);
    iterations_i[k*ITER_W +: ITER_W] = ITER_W'(v);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick(2);
    reset_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_dones(input int n, input int budget);
    int seen;
    int c;
    seen = 0;
    c = 0;
    while (seen < n && c < budget) begin
      @(negedge clk);
      c++;
      if (|done_o) seen++;
    end
    if (seen < n) check_eq("wait_dones_timeout", 32'(seen), 32'(n));
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (|done_o) cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int cnt;
    reset_i      = 1'b1;
    req_i        = '0;
    iterations_i = '0;
    tick(3);
    // reset values
    check_eq("rst_grant", 32'(grant_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_result", 32'(result_o), 32'd0);
    check_eq("rst_overflow", 32'(overflow_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_start", 32'(gen_start_o), 32'd0);
    check_eq("rst_gen_iter", 32'(gen_iterations_o), 32'd0);
    check_eq("rst_timeout", 32'(timeout_o), 32'd0);
    reset_i = 1'b0;
    tick(1);

    // 1: single request, fixed 20-cycle generator latency
    gen_delay = 20;
    set_iter(0, 10);
    push_exp(0, 10, 55, 1'b0, 1'b0);
    s0 = start_cnt;
    req_i = 4'b0001;
    tick(1);
    check_eq("t1_grant_latency", 32'(grant_o), 32'h1);
    check_eq("t1_start_pulse", 32'(gen_start_o), 32'd1);
    req_i = 4'b0000;   // drop while granted
    set_iter(0, 3);    // change after latch
    tick(1);
    check_eq("t1_start_one_cycle", 32'(gen_start_o), 32'd0);
    check_eq("t1_iter_stable", 32'(gen_iterations_o), 32'd10);
    check_eq("t1_busy", 32'(busy_o), 32'd1);
    wait_dones(1, 100);
    tick(1);
    check_eq("t1_start_count", 32'(start_cnt - s0), 32'd1);
    check_eq("t1_grant_cleared", 32'(grant_o), 32'd0);
    check_eq("t1_idle", 32'(busy_o), 32'd0);
    check_eq("t1_result_holds", 32'(result_o), 32'd55);

    // 2: all four request, random generator latency
    do_reset();
    gen_delay = 0;
    set_iter(0, 1);
    set_iter(1, 2);
    set_iter(2, 3);
    set_iter(3, 4);
    push_exp(0, 1, 1, 1'b0, 1'b0);
    push_exp(1, 2, 1, 1'b0, 1'b0);
    push_exp(2, 3, 2, 1'b0, 1'b0);
    push_exp(3, 4, 3, 1'b0, 1'b0);
    push_exp(0, 1, 1, 1'b0, 1'b0);
    req_i = 4'b1111;
    wait_dones(5, 300);
    req_i = 4'b0000;
    tick(3);
    check_eq("t2_queue_drained", 32'(exp_q.size()), 32'd0);

    // 3: wrap-around priority after serving requester 2
    set_iter(1, 5);
    set_iter(2, 7);
    push_exp(2, 7, 13, 1'b0, 1'b0);
    push_exp(1, 5, 5, 1'b0, 1'b0);
    push_exp(2, 7, 13, 1'b0, 1'b0);
    req_i = 4'b0100;
    wait_dones(1, 100);
    req_i = 4'b0110;
    wait_dones(2, 200);
    req_i = 4'b0000;
    tick(3);
    check_eq("t3_queue_drained", 32'(exp_q.size()), 32'd0);

    // 4: generator overflow
    gen_force_ov = 1'b1;
    set_iter(3, 30);
    push_exp(3, 30, 'h3FFF, 1'b1, 1'b0);
    req_i = 4'b1000;
    wait_dones(1, 100);
    req_i = 4'b0000;
    gen_force_ov = 1'b0;
    tick(1);
    check_eq("t4_overflow_holds", 32'(overflow_o), 32'd1);

    // 5: reset during WAIT, then a stale gen_done_i
    gen_silent = 1'b1;
    set_iter(2, 9);
    push_exp(2, 9, 34, 1'b0, 1'b0);
    req_i = 4'b0100;
    tick(5);
    check_eq("t5_busy_in_wait", 32'(busy_o), 32'd1);
    reset_i = 1'b1;
    tick(1);
    check_eq("t5_rst_grant", 32'(grant_o), 32'd0);
    check_eq("t5_rst_busy", 32'(busy_o), 32'd0);
    check_eq("t5_rst_done", 32'(done_o), 32'd0);
    check_eq("t5_rst_result", 32'(result_o), 32'd0);
    check_eq("t5_rst_gen_iter", 32'(gen_iterations_o), 32'd0);
    exp_q.delete();
    reset_i = 1'b0;
    req_i   = 4'b0000;
    inject_req++;
    count_dones(8, cnt);
    check_eq("t5_no_stale_done", 32'(cnt), 32'd0);
    check_eq("t5_still_idle", 32'(busy_o), 32'd0);
    gen_silent = 1'b0;
    push_exp(2, 9, 34, 1'b0, 1'b0);
    req_i = 4'b0100;
    wait_dones(1, 100);
    req_i = 4'b0000;
    tick(2);

`ifdef FIB_ARB_WATCHDOG_EN
    // 6: silent generator triggers the watchdog
    gen_silent = 1'b1;
    set_iter(0, 10);
    push_exp(0, 10, 0, 1'b1, 1'b1);
    req_i = 4'b0001;
    wait_dones(1, 200);
    req_i = 4'b0000;
    inject_req++;
    count_dones(8, cnt);
    check_eq("t6_late_done_ignored", 32'(cnt), 32'd0);
    gen_silent = 1'b0;
`endif

    tick(3);
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
